pipe_stage_reg: RTL and testbench

//  Generic parametrised inter-stage pipeline register for the MiniMIPS32 core.

---
 rtl/pipe_stage_reg.sv | 86 ++++++++
 tb/tb_pipe_stage_reg.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register for MiniMIPS32: valid-tagged payload
// chain of DEPTH slots with hold-vs-bubble stall handling and saturating counters.
module pipe_stage_reg #(
   parameter int                 DATA_W    = 64,
   parameter int                 STALL_W   = 6,
   parameter int                 STAGE_IDX = 3,
   parameter int                 DEPTH     = 1,
   parameter logic [DATA_W-1:0]  NOP_DATA  = '0,
   parameter int                 CNT_W     = 16
) (
   input  logic               cpu_clk_50M,
   input  logic               cpu_rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               cnt_clr,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   hold_cnt
);

   logic              up;
   logic              dn;
   logic              hold_cyc;
   logic              bubble_cyc;
   logic              slot_v [DEPTH];
   logic [DATA_W-1:0] slot_d [DEPTH];

   assign up = stall[STAGE_IDX];

   // The last stage of the stall vector has no downstream stall bit to honour.
   generate
      if (STAGE_IDX == STALL_W - 1) begin : g_dn_none
         assign dn = 1'b0;
      end else begin : g_dn_bit
         assign dn = stall[STAGE_IDX + 1];
      end
   endgenerate

   assign hold_cyc   = up && dn;
   assign bubble_cyc = up && !dn;

   // Slot chain: a stalled upstream feeds a NOP into slot 0 unless downstream is
   // also stalled, in which case the whole chain freezes.
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst || flush) begin
         for (int k = 0; k < DEPTH; k++) begin
            slot_v[k] <= 1'b0;
            slot_d[k] <= NOP_DATA;
         end
      end else if (hold_cyc) begin
      end else begin
         slot_v[0] <= !up && in_valid;
         slot_d[0] <= (!up && in_valid) ? in_data : NOP_DATA;
         for (int k = 1; k < DEPTH; k++) begin
            slot_v[k] <= slot_v[k-1];
            slot_d[k] <= slot_d[k-1];
         end
      end
   end

   // Counters stick at all-ones; a clear beats an increment, a flush suppresses it.
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst || cnt_clr) begin
         bubble_cnt <= '0;
         hold_cnt   <= '0;
      end else if (!flush) begin
         if (hold_cyc && hold_cnt != {CNT_W{1'b1}})
            hold_cnt <= hold_cnt + 1'b1;
         if (bubble_cyc && bubble_cnt != {CNT_W{1'b1}})
            bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

   assign out_valid = slot_v[DEPTH-1];
   assign out_data  = slot_d[DEPTH-1];

   // The stall controller never stalls downstream while upstream runs.
   a_stall_legal : assert property (@(posedge cpu_clk_50M) disable iff (cpu_rst)
      !(!up && dn));
   a_stall_known : assert property (@(posedge cpu_clk_50M) disable iff (cpu_rst)
      !$isunknown(stall));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (DEPTH=2, CNT_W=4): per-cycle expectations are
// queued by the driver and compared by an independent monitor process.
module tb_pipe_stage_reg;

   localparam int         DATA_W = 8;
   localparam int         CNT_W  = 4;
   localparam logic [7:0] NOP    = 8'h3C;
   localparam logic [5:0] RUN    = 6'b000000;
   localparam logic [5:0] HOLD   = 6'b011000;
   localparam logic [5:0] BUBL   = 6'b001000;

   logic              cpu_clk_50M = 1'b0;
   logic              cpu_rst     = 1'b1;
   logic [5:0]        stall       = '0;
   logic              flush       = 1'b0;
   logic              in_valid    = 1'b0;
   logic [DATA_W-1:0] in_data     = '0;
   logic              cnt_clr     = 1'b0;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  bubble_cnt;
   logic [CNT_W-1:0]  hold_cnt;

   typedef struct {
      string      tag;
      logic       v;
      logic [7:0] d;
      logic [3:0] b;
      logic [3:0] h;
   } exp_t;

   exp_t expQ[$];
   int   errors = 0;
   int   checks = 0;

   pipe_stage_reg #(
      .DATA_W(DATA_W), .STALL_W(6), .STAGE_IDX(3), .DEPTH(2),
      .NOP_DATA(NOP), .CNT_W(CNT_W)
   ) dut (
      .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .cnt_clr(cnt_clr),
      .out_valid(out_valid), .out_data(out_data),
      .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
   );

   always #5 cpu_clk_50M = ~cpu_clk_50M;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Drives one cycle of inputs and queues the state expected after the next edge.
   task automatic applyStimulus(input string tag, input logic [5:0] st, input logic fl,
                                input logic rs, input logic iv, input logic [7:0] id,
                                input logic clr, input logic ev, input logic [7:0] ed,
                                input logic [3:0] eb, input logic [3:0] eh);
      exp_t e;
      @(negedge cpu_clk_50M);
      stall = st; flush = fl; cpu_rst = rs; in_valid = iv; in_data = id; cnt_clr = clr;
      e.tag = tag; e.v = ev; e.d = ed; e.b = eb; e.h = eh;
      expQ.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge cpu_clk_50M);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({e.tag, ".valid"},  {15'd0, out_valid},  {15'd0, e.v});
            checkOutput({e.tag, ".data"},   {8'd0, out_data},    {8'd0, e.d});
            checkOutput({e.tag, ".bubble"}, {12'd0, bubble_cnt}, {12'd0, e.b});
            checkOutput({e.tag, ".hold"},   {12'd0, hold_cnt},   {12'd0, e.h});
         end
      end
   end

   initial begin : driver
      int waitCycles;
      // T1 reset with valid input present
      applyStimulus("t1_reset",  RUN, 0, 1, 1, 8'hA5, 0, 0, NOP, 0, 0);
      applyStimulus("t1_idle",   RUN, 0, 0, 0, 8'h00, 0, 0, NOP, 0, 0);
      // T2 two-cycle latency
      applyStimulus("t2_in11",   RUN, 0, 0, 1, 8'h11, 0, 0, NOP,   0, 0);
      applyStimulus("t2_in22",   RUN, 0, 0, 1, 8'h22, 0, 1, 8'h11, 0, 0);
      applyStimulus("t2_in33",   RUN, 0, 0, 1, 8'h33, 0, 1, 8'h22, 0, 0);
      // T3 hold freezes, bubble shifts a NOP in
      applyStimulus("t3_hold1",  HOLD, 0, 0, 1, 8'h44, 0, 1, 8'h22, 0, 1);
      applyStimulus("t3_hold2",  HOLD, 0, 0, 1, 8'h44, 0, 1, 8'h22, 0, 2);
      applyStimulus("t3_hold3",  HOLD, 0, 0, 1, 8'h44, 0, 1, 8'h22, 0, 3);
      applyStimulus("t3_bubble", BUBL, 0, 0, 1, 8'h55, 0, 1, 8'h33, 1, 3);
      applyStimulus("t3_drain1", RUN,  0, 0, 0, 8'h00, 0, 0, NOP,   1, 3);
      applyStimulus("t3_drain2", RUN,  0, 0, 0, 8'h00, 0, 0, NOP,   1, 3);
      // T4 flush beats hold, counters untouched
      applyStimulus("t4_in66",   RUN,  0, 0, 1, 8'h66, 0, 0, NOP,   1, 3);
      applyStimulus("t4_in77",   RUN,  0, 0, 1, 8'h77, 0, 1, 8'h66, 1, 3);
      applyStimulus("t4_flush",  HOLD, 1, 0, 1, 8'h88, 0, 0, NOP,   1, 3);
      applyStimulus("t4_hold",   HOLD, 0, 0, 1, 8'h88, 0, 0, NOP,   1, 4);
      applyStimulus("t4_run",    RUN,  0, 0, 0, 8'h00, 0, 0, NOP,   1, 4);
      applyStimulus("t5_clr",    RUN,  0, 0, 0, 8'h00, 1, 0, NOP,   0, 0);
      // T5 bubble counter saturates at 15, clear beats increment
      for (int i = 1; i <= 20; i++)
         applyStimulus($sformatf("t5_bub%0d", i), BUBL, 0, 0, 1, 8'h99, 0, 0, NOP,
                       (i > 15) ? 4'd15 : 4'(i), 0);
      applyStimulus("t5_bubclr", BUBL, 0, 0, 1, 8'h99, 1, 0, NOP, 0, 0);
      applyStimulus("t5_bubpost",BUBL, 0, 0, 1, 8'h99, 0, 0, NOP, 1, 0);
      // T6 invalid entry carries NOP, not its stale payload
      applyStimulus("t6_inAB",   RUN, 0, 0, 1, 8'hAB, 0, 0, NOP,   1, 0);
      applyStimulus("t6_invFF",  RUN, 0, 0, 0, 8'hFF, 0, 1, 8'hAB, 1, 0);
      applyStimulus("t6_outNop", RUN, 0, 0, 0, 8'hFF, 0, 0, NOP,   1, 0);
      // Reset clears a loaded chain and the counters
      applyStimulus("r_inCD",    RUN, 0, 0, 1, 8'hCD, 0, 0, NOP,   1, 0);
      applyStimulus("r_inEE",    RUN, 0, 0, 1, 8'hEE, 0, 1, 8'hCD, 1, 0);
      applyStimulus("r_reset",   RUN, 0, 1, 1, 8'hEE, 0, 0, NOP,   0, 0);
      applyStimulus("r_after",   RUN, 0, 0, 0, 8'h00, 0, 0, NOP,   0, 0);

      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 10) begin
         @(negedge cpu_clk_50M);
         waitCycles++;
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: actual=%0d pending required=0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
